// File: rtl/uart_pkg.sv
// uart_pkg: frame geometry and receiver state encoding shared by the UART transmitter and receiver.
package uart_pkg;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: received-byte valid/ready handshake with per-byte error flags.
interface uart_rx_os_if;
  logic [uart_pkg::DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic pb_error;
  logic sb_error;
  logic ovr_error;
  modport master (output rx_data, rx_valid, pb_error, sb_error, ovr_error, input rx_ready);
  modport slave (input rx_data, rx_valid, pb_error, sb_error, ovr_error, output rx_ready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer; resets high so an idle serial line reads as idle.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= 2'b11;
    else sync_q <= sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling 8N1/8E1 UART receiver with valid/ready output (UART_RX_PARITY_EN enables even parity).
module uart_rx_os
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic rx_in,
  output logic rx_busy,
  uart_rx_os_if.master rx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif
  logic line;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, pb_q, pb_d, sb_q, sb_d, ovr_q, ovr_d;
  logic done, accept, perr;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(rx_in), .q(line));
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  assign perr = perr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) perr_q <= 1'b0;
    else perr_q <= perr_d;
`else
  assign perr = 1'b0;
`endif
  assign done   = tick && state_q == STOP && cnt_q == LAST;
  assign accept = valid_q && rx.rx_ready;
  // The sample counter free-runs modulo OVERSAMPLE, so each DATA/PARITY/STOP sample lands mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (tick) begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = line ? IDLE : START;
        end
        START: if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line ? IDLE : DATA;
        end
        DATA: if (cnt_q == LAST) begin
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BLAST) ? AFTER_DATA : DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt_q == LAST) begin
          perr_d  = ^shift_q ^ line;
          state_d = STOP;
        end
`endif
        STOP: if (cnt_q == LAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // A completion in the same clk as a transfer wins: the new byte is presented without overrun.
  always_comb begin
    data_d  = done ? shift_q : data_q;
    valid_d = done || (valid_q && !rx.rx_ready);
    pb_d    = done ? perr : pb_q && !accept;
    sb_d    = done ? !line : sb_q && !accept;
    ovr_d   = done ? valid_q && !rx.rx_ready : ovr_q && !accept;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pb_q    <= 1'b0;
      sb_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pb_q    <= pb_d;
      sb_q    <= sb_d;
      ovr_q   <= ovr_d;
    end
  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.pb_error  = pb_q;
  assign rx.sb_error  = sb_q;
  assign rx.ovr_error = ovr_q;
  assign rx_busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frame vectors plus hand-written glitch, overrun, reset and continuous-tick sequences.
module tb_uart_rx_os;
  import uart_pkg::*;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct {
    logic [7:0] d;
    logic stop;
    logic pflip;
    logic [7:0] ed;
    logic epb;
    logic esb;
  } vec_t;
  logic clk = 0, rst = 0, tick = 0, rx_in = 1, rx_busy;
  logic [1:0] div = 0;
  bit cont = 0, busy_seen = 0;
  int errors = 0, checks = 0;
  logic [10:0] got[$];
  logic [10:0] e;
  vec_t v[6];
  uart_rx_os_if rx ();
  uart_rx_os dut (.clk(clk), .rst(rst), .tick(tick), .rx_in(rx_in), .rx_busy(rx_busy), .rx(rx));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    div = div + 1'b1;
    tick = cont || div == 2'd0;
  end
  always @(negedge clk) begin
    if (rx.rx_valid && rx.rx_ready) got.push_back({rx.rx_data, rx.pb_error, rx.sb_error, rx.ovr_error});
    if (rx_busy) busy_seen = 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
  endtask
  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    rx_in = b;
    wait_ticks(n);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic pflip);
    send_bit(1'b0, OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i], OVERSAMPLE);
    if (PAR) send_bit(^d ^ pflip, OVERSAMPLE);
    send_bit(stop_bit, stop_bit ? OVERSAMPLE : 12);
    send_bit(1'b1, 24);
  endtask
  task automatic chk_one(input string name, input logic [7:0] ed, input logic epb, input logic esb);
    @(negedge clk);
    chk({name, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      e = got.pop_front();
      chk({name, "_data"}, e[10:3], ed);
      chk({name, "_pb"}, e[2], epb);
      chk({name, "_sb"}, e[1], esb);
      chk({name, "_ovr"}, e[0], 0);
    end
    chk({name, "_busy"}, rx_busy, 0);
    chk({name, "_valid_clr"}, rx.rx_valid, 0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    v[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    v[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    v[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, PAR, 1'b0};
    v[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    v[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    v[5] = '{8'h81, 1'b0, 1'b1, 8'h81, PAR, 1'b1};
    rx.rx_ready = 1;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1;
    busy_seen = 0;
    wait_ticks(100);
    @(negedge clk);
    chk("rst_valid", rx.rx_valid, 0);
    chk("rst_data", rx.rx_data, 0);
    chk("rst_pb", rx.pb_error, 0);
    chk("rst_sb", rx.sb_error, 0);
    chk("rst_ovr", rx.ovr_error, 0);
    chk("rst_busy", rx_busy, 0);
    chk("idle_busy_seen", busy_seen, 0);
    chk("idle_frames", got.size(), 0);
    for (int i = 0; i < 6; i++) begin
      got.delete();
      send_frame(v[i].d, v[i].stop, v[i].pflip);
      chk_one($sformatf("vec%0d", i), v[i].ed, v[i].epb, v[i].esb);
    end
    got.delete();
    busy_seen = 0;
    send_bit(1'b0, 4);
    send_bit(1'b1, 40);
    @(negedge clk);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy", rx_busy, 0);
    chk("glitch_frames", got.size(), 0);
    chk("glitch_valid", rx.rx_valid, 0);
    rx.rx_ready = 0;
    send_frame(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovr1_valid", rx.rx_valid, 1);
    chk("ovr1_data", rx.rx_data, 8'h11);
    chk("ovr1_ovr", rx.ovr_error, 0);
    send_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovr2_valid", rx.rx_valid, 1);
    chk("ovr2_data", rx.rx_data, 8'h22);
    chk("ovr2_ovr", rx.ovr_error, 1);
    rx.rx_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("ovr_clr_valid", rx.rx_valid, 0);
    chk("ovr_clr_ovr", rx.ovr_error, 0);
    chk("ovr_clr_sb", rx.sb_error, 0);
    chk("ovr_clr_pb", rx.pb_error, 0);
    got.delete();
    send_bit(1'b0, OVERSAMPLE);
    send_bit(1'b0, OVERSAMPLE);
    send_bit(1'b1, OVERSAMPLE);
    send_bit(1'b1, 6);
    @(negedge clk);
    chk("mid_busy", rx_busy, 1);
    rst = 0;
    rx_in = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    wait_ticks(40);
    @(negedge clk);
    chk("rstmid_busy", rx_busy, 0);
    chk("rstmid_valid", rx.rx_valid, 0);
    chk("rstmid_frames", got.size(), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    chk_one("after_rst", 8'h81, 1'b0, 1'b0);
    cont = 1;
    got.delete();
    send_frame(8'h5A, 1'b1, 1'b0);
    chk_one("cont_tick", 8'h5A, 1'b0, 1'b0);
    cont = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

16x-oversampling UART receiver: the receive end of the serial link driven by the existing transmitter. Sits between the serial line and downstream consumers; takes a 16x sampling tick from the baud generator, recovers 8N1/8E1 frames by mid-bit sampling, and presents each byte with frame/parity status on a valid/ready handshake. Replaces the baud-clocked receiver for links that need start-bit qualification and backpressure.

## Interface
- DATA_BITS, 8, data bits per frame, LSB first
- OVERSAMPLE, 16, tick pulses per bit period (power of two, ≥8)
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tick  input  1  one-clk-wide 16x oversample enable from baud generator
- rx_in  input  1  serial line, idle high, asynchronous to clk
- rx_ready  input  1  consumer accepts byte when high with rx_valid
- rx_data  output  DATA_BITS  received byte
- rx_valid  output  1  rx_data and flags valid
- pb_error  output  1  parity error for presented byte
- sb_error  output  1  stop-bit (framing) error for presented byte
- ovr_error  output  1  presented byte overwrote an unaccepted one
- rx_busy  output  1  high while a frame is in progress

## Operation
- rx_in passes through a 2-FF synchronizer before any use; all line sampling uses the synchronized value.
- States: IDLE, START, DATA, PARITY, STOP. Sample counter (log2 OVERSAMPLE bits) and bit counter advance only on tick.
- IDLE: on tick with synchronized line low -> START, counter cleared.
- START: at counter = OVERSAMPLE/2-1 (mid start bit) line still low -> DATA, counter cleared; line high -> IDLE (false start, no flags, no output).
- DATA: sample at counter = OVERSAMPLE-1, shift into bit DATA_BITS-1 of shift register (LSB first); after DATA_BITS samples -> PARITY (macro defined) or STOP.
- PARITY: one sample; even parity: error if XOR(data, parity bit) = 1.
- STOP: one sample; line low -> sb_error for this frame. Return to IDLE on the same tick regardless; a low stop sample does not re-trigger START until the line is sampled low in IDLE.
- Completion: rx_data, pb_error, sb_error load; rx_valid set. If rx_valid already high and rx_ready low at completion, new byte overwrites and ovr_error set.
- Handshake: rx_valid && rx_ready transfers; rx_valid, pb_error, sb_error, ovr_error clear next clk unless a completion occurs that same clk (completion wins: new byte presented, ovr_error = 0).
- rx_busy = state != IDLE.

## Timing
- Reset: state IDLE, counters 0, rx_data 0, rx_valid 0, all error flags 0, rx_busy 0. Reset mid-frame abandons it with no output.
- Line-to-state latency: 2 clk synchronizer plus up to one tick.
- rx_valid rises the clk after the tick carrying the stop-bit mid sample; nominal frame-start-to-valid ≈ (1+DATA_BITS+P+0.5) bit periods, P = 1 with parity.
- rx_data stable while rx_valid high and no completion occurs.
- tick held high continuously is legal (simulation speed-up); logic must not assume gaps between ticks.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present, one even-parity bit expected between data and stop, pb_error reported.
- Undefined: PARITY state and parity logic removed, frame is 8N1, pb_error tied 0.

## Structure
- Shared package uart_pkg: state enumeration, OVERSAMPLE default, DATA_BITS default, shared with the transmitter.
- One sub-module: sync_2ff (two-flop synchronizer, reset to 1 so idle line reads high).

## Test plan
- Reset, line idle high, ticks running -> all outputs 0, rx_busy 0 indefinitely.
- Frame 0xA5 (parity enabled, parity bit 0), rx_ready high -> one rx_valid pulse, rx_data 0xA5, all errors 0.
- Low glitch of 4 ticks on idle line -> returns to IDLE, no rx_valid, rx_busy pulses then clears.
- Frame 0x3C with stop bit 0 -> rx_data 0x3C, sb_error 1; with parity bit flipped to 1 -> pb_error 1.
- rx_ready held low, frames 0x11 then 0x22 -> rx_data 0x22, ovr_error 1; raising rx_ready clears all within one clk.
- Assert rst mid-DATA of 0x7E, release, send 0x81 -> only 0x81 presented, no flags.
